// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - ring-oscillator PUF challenge sequencer, response capture and key match
// Optional build macro: PUF_MAJORITY_VOTE_EN (three measurements per challenge, majority-voted).
module puf_challenge_ctrl #(
  parameter int RESP_BITS     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MEAS_CYCLES   = 64,
  parameter int HD_THRESH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     seed,
  input  logic [RESP_BITS-1:0]           enrolled_key,
  input  logic                           puf_response,
  output logic                           puf_enable,
  output logic [1:0]                     puf_challenge,
  output logic                           busy,
  output logic                           done,
  output logic [RESP_BITS-1:0]           response,
  output logic [$clog2(RESP_BITS+1)-1:0] hamming_dist,
  output logic                           match
);

  localparam int HW   = $clog2(RESP_BITS + 1);
  localparam int IW   = $clog2(RESP_BITS);
  localparam int CMAX = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int CW   = $clog2(CMAX + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_CAPTURE, S_COMPARE, S_DONE
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [IW-1:0]          bit_idx;
  logic [7:0]             lfsr;
  logic [RESP_BITS-1:0]   key;
  logic                   sync1, sync2;
  logic                   accept, last_cap, bit_done;
  logic [RESP_BITS-1:0]   diff;
  logic [HW-1:0]          hd_calc;
  logic [7:0]             lfsr_adv;

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] rep;
  logic [1:0] votes;
  assign bit_done = (rep == 2'd2);
`else
  assign bit_done = 1'b1;
`endif

  // x^8+x^6+x^5+x^4+1, shifted left with feedback entering bit 0
  assign lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign puf_enable    = (state == S_MEASURE) || (state == S_CAPTURE);
  assign puf_challenge = (state == S_IDLE) ? 2'b00 : lfsr[1:0];
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign diff          = response ^ key;

  always_comb begin
    hd_calc = '0;
    for (int i = 0; i < RESP_BITS; i++) hd_calc = hd_calc + HW'(diff[i]);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    last_cap   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_MEASURE;
        end else cnt_next = cnt + CW'(1);
      end
      S_MEASURE: begin
        if (cnt == CW'(MEAS_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_CAPTURE;
        end else cnt_next = cnt + CW'(1);
      end
      S_CAPTURE: begin
        // two cycles so the synchronizer reflects the measured oscillator state
        if (cnt == CW'(1)) begin
          cnt_next   = '0;
          last_cap   = 1'b1;
          state_next = (bit_done && bit_idx == IW'(RESP_BITS - 1)) ? S_COMPARE : S_SETTLE;
        end else cnt_next = cnt + CW'(1);
      end
      S_COMPARE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      lfsr         <= 8'hA5;
      key          <= '0;
      response     <= '0;
      hamming_dist <= '0;
      match        <= 1'b0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      rep          <= '0;
      votes        <= '0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sync1 <= puf_response;
      sync2 <= sync1;
      if (accept) begin
        lfsr     <= (seed == 8'h00) ? 8'hA5 : seed;
        key      <= enrolled_key;
        response <= '0;
        bit_idx  <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
        rep      <= '0;
        votes    <= '0;
`endif
      end
      if (last_cap) begin
`ifdef PUF_MAJORITY_VOTE_EN
        if (bit_done) begin
          response[bit_idx] <= ((votes + {1'b0, sync2}) >= 2'd2);
          lfsr              <= lfsr_adv;
          bit_idx           <= bit_idx + IW'(1);
          rep               <= '0;
          votes             <= '0;
        end else begin
          rep   <= rep + 2'd1;
          votes <= votes + {1'b0, sync2};
        end
`else
        response[bit_idx] <= sync2;
        lfsr              <= lfsr_adv;
        bit_idx           <= bit_idx + IW'(1);
`endif
      end
      if (state == S_COMPARE) begin
        hamming_dist <= hd_calc;
        match        <= (int'(hd_calc) <= HD_THRESH);
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb/tb_puf_challenge_ctrl.sv - randomized bench for puf_challenge_ctrl against a behavioural model
module tb_puf_challenge_ctrl;

  localparam int RB = 16;
  localparam int HT = 2;
  localparam int HW = $clog2(RB + 1);
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int PER_BIT = 3 * (4 + 64 + 2);
`else
  localparam int PER_BIT = 4 + 64 + 2;
`endif
  localparam int RUN_CYC = RB * PER_BIT + 2;
  localparam int LIMIT   = RUN_CYC + 50;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    seed;
  logic [RB-1:0] enrolled_key;
  logic          puf_response;
  logic          puf_enable, busy, done, match;
  logic [1:0]    puf_challenge;
  logic [RB-1:0] response;
  logic [HW-1:0] hamming_dist;

  int   mode;
  logic const_bit;
  logic tog = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  // clk period 52, toggle period 40 (1.3x clk); toggles land on odd times, clk edges on even
  always #26 clk = ~clk;
  initial begin
    #1;
    forever #20 tog = ~tog;
  end

  assign puf_response = (mode == 0) ? puf_challenge[0] :
                        (mode == 1) ? const_bit :
                        (mode == 2) ? tog : puf_challenge[1];

  puf_challenge_ctrl #(.RESP_BITS(RB), .SETTLE_CYCLES(4), .MEAS_CYCLES(64), .HD_THRESH(HT)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .enrolled_key(enrolled_key),
    .puf_response(puf_response), .puf_enable(puf_enable), .puf_challenge(puf_challenge),
    .busy(busy), .done(done), .response(response), .hamming_dist(hamming_dist), .match(match)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // sel=0: PUF echoes challenge[0]; sel=1: PUF echoes challenge[1]
  function automatic logic [RB-1:0] model_resp(input logic [7:0] s, input bit sel);
    logic [7:0]    l;
    logic [RB-1:0] r;
    l = (s == 8'h00) ? 8'hA5 : s;
    r = '0;
    for (int i = 0; i < RB; i++) begin
      r[i] = sel ? l[1] : l[0];
      l = lfsr_step(l);
    end
    return r;
  endfunction

  function automatic int popcnt(input logic [RB-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < RB; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic do_run(input logic [7:0] s, input logic [RB-1:0] key, input bit scramble_key,
                        output int done_cyc, output logic [1:0] first_chal, output logic busy_after);
    done_cyc = -1;
    @(posedge clk); #1;
    seed = s; enrolled_key = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_chal = puf_challenge;
    if (scramble_key) enrolled_key = RB'($urandom);
    for (int c = 1; c <= LIMIT; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({puf_enable, puf_challenge, busy, done, match} !== 6'b0)
      $display("FAIL reset_ctrl: got en=%b chal=%b busy=%b done=%b match=%b, want all 0",
               puf_enable, puf_challenge, busy, done, match);
    else n_pass++;
    n_total++;
    if (response !== '0 || hamming_dist !== '0)
      $display("FAIL reset_data: got resp=%h hd=%0d, want 0/0", response, hamming_dist);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_seed0;
    int dc; logic [1:0] fc; logic ba; logic [RB-1:0] exp;
    mode = 0;
    exp = model_resp(8'h00, 1'b0);
    do_run(8'h00, RB'($urandom), 1'b0, dc, fc, ba);
    n_total++;
    if (fc !== 2'b01) $display("FAIL seed0_first_chal: got %b want 01", fc); else n_pass++;
    n_total++;
    if (dc != RUN_CYC) $display("FAIL seed0_latency: got %0d want %0d", dc, RUN_CYC); else n_pass++;
    n_total++;
    if (response[0] !== 1'b1) $display("FAIL seed0_bit0: got %b want 1", response[0]); else n_pass++;
    n_total++;
    if (response !== exp) $display("FAIL seed0_resp: got %h want %h", response, exp); else n_pass++;
    n_total++;
    if (ba !== 1'b0) $display("FAIL seed0_busy_after_done: got %b want 0", ba); else n_pass++;
  endtask

  task automatic test_midrun_reset;
    logic [7:0] s; logic [RB-1:0] exp;
    mode = 0;
    s = 8'($urandom);
    exp = model_resp(s, 1'b0) & RB'(7);
    @(posedge clk); #1;
    seed = s; enrolled_key = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3 * 70 + 4 + 9) @(posedge clk);
    #1;
    n_total++;
    if (puf_enable !== 1'b1 || response !== exp)
      $display("FAIL midrun_progress: got en=%b resp=%h want en=1 resp=%h", puf_enable, response, exp);
    else n_pass++;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({puf_enable, busy, puf_challenge} !== 4'b0 || response !== '0)
      $display("FAIL midrun_reset: got en=%b busy=%b chal=%b resp=%h want all 0",
               puf_enable, busy, puf_challenge, response);
    else n_pass++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL midrun_restart: got busy=%b want 1", busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_hamming;
    int dc; logic [1:0] fc; logic ba;
    mode = 1; const_bit = 1'b1;
    do_run(8'($urandom), 16'hFFFC, 1'b0, dc, fc, ba);
    n_total++;
    if (response !== 16'hFFFF || hamming_dist !== HW'(2) || match !== 1'b1)
      $display("FAIL hd_fffc: got resp=%h hd=%0d match=%b want ffff/2/1", response, hamming_dist, match);
    else n_pass++;
    do_run(8'($urandom), 16'hFFF8, 1'b0, dc, fc, ba);
    n_total++;
    if (hamming_dist !== HW'(3) || match !== 1'b0)
      $display("FAIL hd_fff8: got hd=%0d match=%b want 3/0", hamming_dist, match);
    else n_pass++;
  endtask

  task automatic test_start_spam;
    logic [7:0] s; logic [RB-1:0] exp; int n_done; int bad; int c;
    mode = 0;
    s = 8'($urandom);
    exp = model_resp(s, 1'b0);
    n_done = 0; bad = 0; c = 0;
    @(posedge clk); #1;
    seed = s; start = 1'b1;
    @(posedge clk); #1;
    while (!done && c < LIMIT) begin
      seed = 8'($urandom);
      start = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) n_done++;
      if (n_done > 0 && response !== exp) bad++;
      @(posedge clk); #1;
    end
    n_total++;
    if (n_done != 1) $display("FAIL spam_done_count: got %0d want 1", n_done); else n_pass++;
    n_total++;
    if (bad != 0 || response !== exp)
      $display("FAIL spam_resp_hold: got %h (%0d bad cycles) want %h", response, bad, exp);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL spam_idle: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_async;
    logic m1, m2, old; logic [RB-1:0] exp;
    mode = 2; m1 = 1'b0; m2 = 1'b0; exp = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      m2 = m1; m1 = puf_response;
    end
    #1;
    seed = 8'($urandom); start = 1'b1;
    @(posedge clk);
    m2 = m1; m1 = puf_response;
    #1;
    start = 1'b0;
    for (int k = 1; k <= RB * PER_BIT; k++) begin
      @(posedge clk);
      old = m2; m2 = m1; m1 = puf_response;
      if (k % PER_BIT == 0) exp[k / PER_BIT - 1] = old;
    end
    #1;
    n_total++;
    if ($isunknown(response) || response !== exp)
      $display("FAIL async_resp: got %h want %h", response, exp);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b1) $display("FAIL async_done: got %b want 1", done); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int dc; logic [1:0] fc; logic ba; logic [7:0] s; logic [RB-1:0] key, exp; bit sel; int hd;
    for (int r = 0; r < 4; r++) begin
      sel  = 1'($urandom);
      mode = sel ? 3 : 0;
      s    = 8'($urandom);
      key  = RB'($urandom);
      exp  = model_resp(s, sel);
      if (r == 0) key = exp ^ RB'(3);
      hd   = popcnt(exp ^ key);
      do_run(s, key, 1'b1, dc, fc, ba);
      n_total++;
      if (dc != RUN_CYC || response !== exp)
        $display("FAIL rand_run%0d: got lat=%0d resp=%h want lat=%0d resp=%h", r, dc, response, RUN_CYC, exp);
      else n_pass++;
      n_total++;
      if (int'(hamming_dist) != hd || match !== (hd <= HT))
        $display("FAIL rand_cmp%0d: got hd=%0d match=%b want hd=%0d match=%b",
                 r, hamming_dist, match, hd, (hd <= HT));
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; enrolled_key = '0; mode = 0; const_bit = 1'b0;
    test_reset;
    test_seed0;
    test_midrun_reset;
    test_hamming;
    test_start_spam;
    test_async;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
